router_fsm_ctrl: RTL

Packet-sequencing controller for the 1x3 router input path. Decodes the destination address from the header byte, then walks the packet through header load, payload load, FIFO-full stall, and parity load/check. It drives the control strobes consumed by the router register block (header/payload/parity capture and error check) and the write enables consumed by the FIFO synchronizer. One controller instance serves the single input port and all three output FIFOs.

---
 rtl/router_fsm_ctrl_pkg.sv | 30 +++
 rtl/router_fsm_ctrl_if.sv | 39 +++
 rtl/router_fsm_ctrl.sv | 81 ++++++++
 3 files changed

// File: rtl/router_fsm_ctrl_pkg.sv
// Shared router definitions: controller state encoding, port count and
// address helpers used by the input-path sequencing logic.
package router_fsm_ctrl_pkg;

    localparam int              NUM_PORTS    = 3;
    localparam int              ADDR_W       = 2;
    localparam logic [ADDR_W-1:0] ADDR_INVALID = 2'b11;

    typedef enum logic [2:0] {
        DECODE_ADDRESS     = 3'd0,
        LOAD_FIRST_DATA    = 3'd1,
        LOAD_DATA          = 3'd2,
        FIFO_FULL_STATE    = 3'd3,
        LOAD_AFTER_FULL    = 3'd4,
        LOAD_PARITY        = 3'd5,
        CHECK_PARITY_ERROR = 3'd6,
        WAIT_TILL_EMPTY    = 3'd7
    } state_e;

    function automatic logic addr_valid(input logic [ADDR_W-1:0] a);
        return (a != ADDR_INVALID) && (int'(a) < NUM_PORTS);
    endfunction

    // Per-port flag lookup that reads as 0 for an out-of-range address.
    function automatic logic port_bit(input logic [NUM_PORTS-1:0] v,
                                      input logic [ADDR_W-1:0]    a);
        return addr_valid(a) ? v[a] : 1'b0;
    endfunction

endpackage

// File: rtl/router_fsm_ctrl_if.sv
// Handshake bundle between the router input path, register block and FIFO
// synchronizer on one side and the sequencing controller on the other.
interface router_fsm_ctrl_if;
    import router_fsm_ctrl_pkg::*;

    logic                  pkt_valid;
    logic [ADDR_W-1:0]     data_in;
    logic                  fifo_full;
    logic [NUM_PORTS-1:0]  fifo_empty;
    logic [NUM_PORTS-1:0]  soft_reset;
    logic                  parity_done;
    logic                  low_pkt_valid;

    logic [ADDR_W-1:0]     addr_q;
    logic                  detect_add;
    logic                  lfd_state;
    logic                  ld_state;
    logic                  laf_state;
    logic                  full_state;
    logic                  rst_int_reg;
    logic                  write_enb_reg;
    logic [NUM_PORTS-1:0]  write_enb;
    logic                  busy;

    modport slave (
        input  pkt_valid, data_in, fifo_full, fifo_empty, soft_reset,
               parity_done, low_pkt_valid,
        output addr_q, detect_add, lfd_state, ld_state, laf_state, full_state,
               rst_int_reg, write_enb_reg, write_enb, busy
    );

    modport master (
        output pkt_valid, data_in, fifo_full, fifo_empty, soft_reset,
               parity_done, low_pkt_valid,
        input  addr_q, detect_add, lfd_state, ld_state, laf_state, full_state,
               rst_int_reg, write_enb_reg, write_enb, busy
    );

endinterface

// File: rtl/router_fsm_ctrl.sv
// Packet-sequencing controller for the 1x3 router input port: decodes the
// header address and walks the packet through load, stall and parity states.
module router_fsm_ctrl
    import router_fsm_ctrl_pkg::*;
(
    input  logic              clk,
    input  logic              reset,
    router_fsm_ctrl_if.slave  bus
);

    state_e              state_q, state_d;
    logic [ADDR_W-1:0]   addr_reg_q, addr_d;
    logic                sr_hit;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= DECODE_ADDRESS;
            addr_reg_q <= '0;
        end else begin
            state_q    <= state_d;
            addr_reg_q <= addr_d;
        end
    end

    always_comb begin
        state_d = state_q;
        addr_d  = addr_reg_q;
        // Timeout on the selected FIFO aborts the packet; other ports' timeouts are not ours.
        sr_hit  = (state_q != DECODE_ADDRESS) && port_bit(bus.soft_reset, addr_reg_q);

        case (state_q)
            DECODE_ADDRESS: begin
                if (bus.pkt_valid) begin
                    addr_d = bus.data_in;
                    if (addr_valid(bus.data_in))
                        state_d = port_bit(bus.fifo_empty, bus.data_in) ? LOAD_FIRST_DATA
                                                                        : WAIT_TILL_EMPTY;
                end
            end
            LOAD_FIRST_DATA: state_d = LOAD_DATA;
            LOAD_DATA: begin
                if (bus.fifo_full)       state_d = FIFO_FULL_STATE;
                else if (!bus.pkt_valid) state_d = LOAD_PARITY;
            end
            FIFO_FULL_STATE: begin
                if (!bus.fifo_full) state_d = LOAD_AFTER_FULL;
            end
            LOAD_AFTER_FULL: begin
                if (bus.parity_done)        state_d = DECODE_ADDRESS;
                else if (bus.low_pkt_valid) state_d = LOAD_PARITY;
                else                        state_d = LOAD_DATA;
            end
            LOAD_PARITY: state_d = CHECK_PARITY_ERROR;
            CHECK_PARITY_ERROR: begin
                state_d = bus.fifo_full ? FIFO_FULL_STATE : DECODE_ADDRESS;
            end
            WAIT_TILL_EMPTY: begin
                if (port_bit(bus.fifo_empty, addr_reg_q)) state_d = LOAD_FIRST_DATA;
            end
            default: state_d = DECODE_ADDRESS;
        endcase

        if (sr_hit) state_d = DECODE_ADDRESS;
    end

    assign bus.addr_q        = addr_reg_q;
    assign bus.detect_add    = (state_q == DECODE_ADDRESS);
    assign bus.lfd_state     = (state_q == LOAD_FIRST_DATA);
    assign bus.ld_state      = (state_q == LOAD_DATA);
    assign bus.laf_state     = (state_q == LOAD_AFTER_FULL);
    assign bus.full_state    = (state_q == FIFO_FULL_STATE);
    assign bus.rst_int_reg   = (state_q == CHECK_PARITY_ERROR);
    assign bus.write_enb_reg = (state_q == LOAD_DATA) || (state_q == LOAD_PARITY) ||
                               (state_q == LOAD_AFTER_FULL);
    assign bus.busy          = (state_q != DECODE_ADDRESS) && (state_q != LOAD_DATA);

    for (genvar p = 0; p < NUM_PORTS; p++) begin : g_wen
        assign bus.write_enb[p] = bus.write_enb_reg && (addr_reg_q == ADDR_W'(p));
    end

endmodule
